// File: rtl/core_pkg.sv
// Shared core definitions: writeback source encoding, load funct3 codes and
// datapath width defaults used by the MEM/WB stage and its helpers.
package core_pkg;

    localparam int DATA_W_DEFAULT     = 32;
    localparam int REG_ADDR_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_LINK = 2'd2
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the byte/half/word lane addressed by addr_lo
// from the raw memory word and sign- or zero-extends it to DATA_W.
module load_align
    import core_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [DATA_W-1:0] ram_data,
    input  logic [2:0]        addr_lo,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] data
);

    logic [2:0]        off_b;
    logic [2:0]        off_h;
    logic [2:0]        off_w;
    logic [DATA_W-1:0] shift_b;
    logic [DATA_W-1:0] shift_h;
    logic [DATA_W-1:0] shift_w;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       lane_w;

    // Byte offsets per lane size; bit 2 only matters on a 64-bit datapath.
    assign off_b = (DATA_W == 64) ? addr_lo : {1'b0, addr_lo[1:0]};
    assign off_h = (DATA_W == 64) ? {addr_lo[2:1], 1'b0} : {1'b0, addr_lo[1], 1'b0};
    assign off_w = (DATA_W == 64) ? {addr_lo[2], 2'b00} : 3'b000;

    assign shift_b = ram_data >> {off_b, 3'b000};
    assign shift_h = ram_data >> {off_h, 3'b000};
    assign shift_w = ram_data >> {off_w, 3'b000};

    assign lane_b = shift_b[7:0];
    assign lane_h = shift_h[15:0];
    assign lane_w = shift_w[31:0];

    always_comb begin
        data = ram_data;
        case (funct3)
            F3_LB:   data = DATA_W'($signed(lane_b));
            F3_LH:   data = DATA_W'($signed(lane_h));
            F3_LW:   data = DATA_W'($signed(lane_w));
            F3_LBU:  data = DATA_W'(lane_b);
            F3_LHU:  data = DATA_W'(lane_h);
            F3_LWU:  data = DATA_W'(lane_w);
            default: data = ram_data;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: selects the writeback value, suppresses x0
// writes, supports stall/flush and counts retired instructions.
module mem_wb_stage
    import core_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [1:0]            wb_sel_in,
    input  logic [2:0]            load_funct3_in,
    input  logic [2:0]            addr_lo_in,
    input  logic [DATA_W-1:0]     alu_data_in,
    input  logic [DATA_W-1:0]     ram_data_in,
    input  logic [DATA_W-1:0]     pc_plus4_in,
    input  logic                  write_enable_in,
    input  logic [REG_ADDR_W-1:0] wb_addr_in,
    output logic                  write_enable_out,
    output logic [REG_ADDR_W-1:0] wb_addr_out,
    output logic [DATA_W-1:0]     wb_data_out,
    output logic                  valid_out,
    output logic                  fwd_valid_out,
    output logic [CNT_W-1:0]      retired_count_out
);

    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] wb_data_next;
    logic              we_next;

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .ram_data (ram_data_in),
        .addr_lo  (addr_lo_in),
        .funct3   (load_funct3_in),
        .data     (load_data)
    );

    // The reserved encoding (3) falls through to the ALU result.
    always_comb begin
        wb_data_next = alu_data_in;
        case (wb_sel_in)
            WB_LOAD: wb_data_next = load_data;
            WB_LINK: wb_data_next = pc_plus4_in;
            default: wb_data_next = alu_data_in;
        endcase
    end

    assign we_next = write_enable_in & valid_in & (wb_addr_in != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_enable_out  <= 1'b0;
            wb_addr_out       <= '0;
            wb_data_out       <= '0;
            valid_out         <= 1'b0;
            retired_count_out <= '0;
        end else if (flush) begin
            write_enable_out  <= 1'b0;
            wb_addr_out       <= '0;
            wb_data_out       <= '0;
            valid_out         <= 1'b0;
        end else if (!stall) begin
            write_enable_out  <= we_next;
            wb_addr_out       <= wb_addr_in;
            wb_data_out       <= wb_data_next;
            valid_out         <= valid_in;
            if (valid_in) begin
                retired_count_out <= retired_count_out + CNT_W'(1);
            end
        end
    end

    assign fwd_valid_out = write_enable_out;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a reference model pushes expected stage
// contents to a queue as each step is driven; they are popped after the edge.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        valid_in;
    logic [1:0]  wb_sel_in;
    logic [2:0]  load_funct3_in;
    logic [2:0]  addr_lo_in;
    logic [31:0] alu_data_in;
    logic [31:0] ram_data_in;
    logic [31:0] pc_plus4_in;
    logic        write_enable_in;
    logic [4:0]  wb_addr_in;

    logic        write_enable_out;
    logic [4:0]  wb_addr_out;
    logic [31:0] wb_data_out;
    logic        valid_out;
    logic        fwd_valid_out;
    logic [63:0] retired_count_out;

    logic        we4;
    logic [4:0]  addr4;
    logic [31:0] data4;
    logic        valid4;
    logic        fwd4;
    logic [3:0]  count4;

    typedef struct {
        logic        v;
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic [63:0] c;
        logic [3:0]  c4;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(64)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .flush             (flush),
        .valid_in          (valid_in),
        .wb_sel_in         (wb_sel_in),
        .load_funct3_in    (load_funct3_in),
        .addr_lo_in        (addr_lo_in),
        .alu_data_in       (alu_data_in),
        .ram_data_in       (ram_data_in),
        .pc_plus4_in       (pc_plus4_in),
        .write_enable_in   (write_enable_in),
        .wb_addr_in        (wb_addr_in),
        .write_enable_out  (write_enable_out),
        .wb_addr_out       (wb_addr_out),
        .wb_data_out       (wb_data_out),
        .valid_out         (valid_out),
        .fwd_valid_out     (fwd_valid_out),
        .retired_count_out (retired_count_out)
    );

    mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) dut4 (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .flush             (flush),
        .valid_in          (valid_in),
        .wb_sel_in         (wb_sel_in),
        .load_funct3_in    (load_funct3_in),
        .addr_lo_in        (addr_lo_in),
        .alu_data_in       (alu_data_in),
        .ram_data_in       (ram_data_in),
        .pc_plus4_in       (pc_plus4_in),
        .write_enable_in   (write_enable_in),
        .wb_addr_in        (wb_addr_in),
        .write_enable_out  (we4),
        .wb_addr_out       (addr4),
        .wb_data_out       (data4),
        .valid_out         (valid4),
        .fwd_valid_out     (fwd4),
        .retired_count_out (count4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs; expd is the writeback value the bench
    // expects to be captured if this slot is taken.
    task automatic step(input string tag, input logic r, input logic s, input logic f,
                        input logic v, input logic [1:0] sel, input logic [2:0] f3,
                        input logic [2:0] off, input logic [31:0] alu, input logic [31:0] ram,
                        input logic [31:0] pc, input logic we, input logic [4:0] wa,
                        input logic [31:0] expd);
        exp_t e;
        rst_n = r; stall = s; flush = f; valid_in = v; wb_sel_in = sel;
        load_funct3_in = f3; addr_lo_in = off; alu_data_in = alu; ram_data_in = ram;
        pc_plus4_in = pc; write_enable_in = we; wb_addr_in = wa;
        if (!r) begin
            m.v = 0; m.we = 0; m.a = 0; m.d = 0; m.c = 0; m.c4 = 0;
        end else if (f) begin
            m.v = 0; m.we = 0; m.a = 0; m.d = 0;
        end else if (!s) begin
            m.v = v; m.we = we && v && (wa != 0); m.a = wa; m.d = expd;
            if (v) begin
                m.c = m.c + 64'd1;
                m.c4 = m.c4 + 4'd1;
            end
        end
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 64'(valid_out), 64'(e.v));
            check({tag, "_we"},    64'(write_enable_out), 64'(e.we));
            check({tag, "_fwd"},   64'(fwd_valid_out), 64'(e.we));
            check({tag, "_addr"},  64'(wb_addr_out), 64'(e.a));
            check({tag, "_data"},  64'(wb_data_out), 64'(e.d));
            check({tag, "_cnt"},   retired_count_out, e.c);
            check({tag, "_cnt4"},  64'(count4), 64'(e.c4));
        end
    endtask

    localparam logic [31:0] RAM = 32'h8000_7F80;

    initial begin
        m = '{v: 0, we: 0, a: 0, d: 0, c: 0, c4: 0};

        step("rst0", 0, 0, 0, 1, 2'd0, 3'd0, 3'd0, 32'h1234, RAM, 32'h8, 1, 5'd5, 32'h0);
        step("rst1", 0, 1, 1, 1, 2'd1, 3'd2, 3'd1, 32'h1234, RAM, 32'h8, 1, 5'd5, 32'h0);
        step("rel",  1, 0, 0, 0, 2'd0, 3'd0, 3'd0, 32'h0,    32'h0, 32'h0, 0, 5'd0, 32'h0);

        step("lb0",  1, 0, 0, 1, 2'd1, 3'd0, 3'd0, 32'h0, RAM, 32'h0, 1, 5'd3, 32'hFFFF_FF80);
        step("lbu0", 1, 0, 0, 1, 2'd1, 3'd4, 3'd0, 32'h0, RAM, 32'h0, 1, 5'd3, 32'h0000_0080);
        step("lb1",  1, 0, 0, 1, 2'd1, 3'd0, 3'd1, 32'h0, RAM, 32'h0, 1, 5'd3, 32'h0000_007F);
        step("lb3",  1, 0, 0, 1, 2'd1, 3'd0, 3'd3, 32'h0, RAM, 32'h0, 1, 5'd3, 32'hFFFF_FF80);
        step("lbu1", 1, 0, 0, 1, 2'd1, 3'd4, 3'd1, 32'h0, RAM, 32'h0, 1, 5'd3, 32'h0000_007F);
        step("lh2",  1, 0, 0, 1, 2'd1, 3'd1, 3'd2, 32'h0, RAM, 32'h0, 1, 5'd4, 32'hFFFF_8000);
        step("lhu2", 1, 0, 0, 1, 2'd1, 3'd5, 3'd2, 32'h0, RAM, 32'h0, 1, 5'd4, 32'h0000_8000);
        step("lh0",  1, 0, 0, 1, 2'd1, 3'd1, 3'd0, 32'h0, RAM, 32'h0, 1, 5'd4, 32'h0000_7F80);
        step("lw",   1, 0, 0, 1, 2'd1, 3'd2, 3'd0, 32'h0, RAM, 32'h0, 1, 5'd6, 32'h8000_7F80);
        step("ld32", 1, 0, 0, 1, 2'd1, 3'd3, 3'd0, 32'h0, RAM, 32'h0, 1, 5'd6, 32'h8000_7F80);

        step("link", 1, 0, 0, 1, 2'd2, 3'd0, 3'd0, 32'h55, RAM, 32'h104, 1, 5'd1, 32'h104);
        step("alu",  1, 0, 0, 1, 2'd0, 3'd0, 3'd0, 32'hDEAD_BEEF, RAM, 32'h104, 1, 5'd2, 32'hDEAD_BEEF);
        step("rsv",  1, 0, 0, 1, 2'd3, 3'd0, 3'd0, 32'h0000_CAFE, RAM, 32'h104, 1, 5'd7, 32'h0000_CAFE);

        step("x0",   1, 0, 0, 1, 2'd0, 3'd0, 3'd0, 32'h1111, 32'h0, 32'h0, 1, 5'd0, 32'h1111);
        step("inv",  1, 0, 0, 0, 2'd0, 3'd0, 3'd0, 32'h2222, 32'h0, 32'h0, 1, 5'd7, 32'h2222);

        step("capA", 1, 0, 0, 1, 2'd0, 3'd0, 3'd0, 32'hAAAA_5555, 32'h0, 32'h0, 1, 5'd9, 32'hAAAA_5555);
        for (int i = 0; i < 3; i++) begin
            step("stl", 1, 1, 0, 1, 2'd0, 3'd0, 3'd0, 32'h3333 + i, 32'h0, 32'h0, 1, 5'd10, 32'h0);
        end
        step("capB", 1, 0, 0, 1, 2'd2, 3'd0, 3'd0, 32'h0, 32'h0, 32'h200, 1, 5'd11, 32'h200);
        step("sfl",  1, 1, 1, 1, 2'd0, 3'd0, 3'd0, 32'h4444, 32'h0, 32'h0, 1, 5'd12, 32'h0);
        step("capC", 1, 0, 0, 1, 2'd0, 3'd0, 3'd0, 32'h5555, 32'h0, 32'h0, 1, 5'd13, 32'h5555);
        step("fl",   1, 0, 1, 1, 2'd0, 3'd0, 3'd0, 32'h6666, 32'h0, 32'h0, 1, 5'd14, 32'h0);
        step("rstst", 0, 1, 0, 1, 2'd0, 3'd0, 3'd0, 32'h7777, 32'h0, 32'h0, 1, 5'd15, 32'h0);

        for (int i = 0; i < 17; i++) begin
            step("wrap", 1, 0, 0, 1, 2'd0, 3'd0, 3'd0, 32'h100 + i, 32'h0, 32'h0, 1, 5'd8, 32'h100 + i);
        end
        check("wrap_cnt4_final", 64'(count4), 64'd1);
        check("wrap_cnt64_final", retired_count_out, 64'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
